ram_sp_1024x32_arb: RTL and testbench
=====================================

// Module: ram_sp_1024x32_arb
// PURPOSE
//  Two-requester arbiter/sequencer for one single-port 1024x32 SRAM (ram_sp_1024x32).
//  Per cycle, grants one read or write from requester 0 or 1. Drives the RAM's
//  address, write and read controls, and returns read data with per-requester valid.
//  Arbitration is round-robin. An optional bounded lock gives a requester back-to-back bursts.
// PARAMETERS
//  ADR_WD    10  RAM address width
//  DAT_WD    32  RAM data width
//  MAX_LOCK  16  max locked cycles while the other requester waits; 0 = unlimited
// PORTS
//  clk           in   1       clock
//  rstn          in   1       async reset, active low
//  req0_i        in   1       requester 0 access request; hold until gnt0_o
//  wen0_i        in   1       requester 0: 1 = write, 0 = read
//  lck0_i        in   1       requester 0 burst lock request
//  adr0_i        in   ADR_WD  requester 0 address
//  dat0_i        in   DAT_WD  requester 0 write data
//  gnt0_o        out  1       requester 0 access accepted this cycle (combinational)
//  rd_vld0_o     out  1       rd_dat_o holds requester 0 read data
//  req1_i/wen1_i/lck1_i/adr1_i/dat1_i/gnt1_o/rd_vld1_o   same, requester 1
//  rd_dat_o      out  DAT_WD  shared read data (= ram_rd_dat_i)
//  ram_adr_o     out  ADR_WD  to RAM adr_i
//  ram_wr_ena_o  out  1       to RAM wr_ena_i (active high)
//  ram_wr_dat_o  out  DAT_WD  to RAM wr_dat_i
//  ram_rd_ena_o  out  1       to RAM rd_ena_i (active high)
//  ram_rd_dat_i  in   DAT_WD  from RAM rd_dat_o
// BEHAVIOUR
//  - Reset: state = ARB, lst_r = 1 (requester 0 wins the first tie), cnt_r = 0,
//    rd_vld0_o = rd_vld1_o = 0. Outputs are driven by grant logic: 0 while no req.
//  - Grant rule: gntX = reqX and permitted by state. At most one grant per cycle.
//    gntX is never high while reqX is low.
//  - RAM drive (combinational from the winner): ram_adr_o = adrX;
//    ram_wr_ena_o = gntX & wenX; ram_rd_ena_o = gntX & ~wenX; ram_wr_dat_o = datX.
//    With no grant, both enables are 0 and adr/dat are don't-care (held at requester 0 values).
//  - Read latency: 1. rd_vldX_o is registered from (gntX & ~wenX) and is high for
//    exactly 1 cycle. rd_dat_o passes ram_rd_dat_i through unregistered.
//    The write cycle itself produces no valid.
//  - ARB state:
//    - Single request: grant it.
//    - Both request: grant ~lst_r. lst_r <= winner on every ARB grant.
//    - If winner X has lckX_i = 1: go to LCKX and set cnt_r <= 0.
//  - LCKX state:
//    - Only X may be granted (gntX = reqX). The other requester is stalled.
//    - cnt_r increments (saturating) only on cycles where the other requester is pending.
//    - Exit to ARB at the clock edge when lckX_i == 0, or when MAX_LOCK != 0,
//      cnt_r == MAX_LOCK-1 and the other requester is pending (forced break).
//    - On exit, lst_r <= X, so the other requester wins the next tie.
//    - The exit cycle still grants only X, so a release costs one cycle.
//  - Simultaneous events: reqX dropping while in LCKX leaves the lock held; only
//    lckX_i releases it. Both lck inputs high has no effect beyond the winner's lock.
//  - Reset mid-operation: any read issued in the reset cycle is lost (rd_vld forced 0).
//    The requester must re-issue it.
//  - Wrap-around: addresses pass through unchanged; no range checking.
// TESTING
//  - Reset: rstn=0 with req0=req1=1 -> gnt=0, ram enables 0, rd_vld=0.
//    First edge after release -> gnt0=1.
//  - Tie: both read continuously, adr0=5, adr1=9 -> grants alternate 0,1,0,1.
//    rd_vldX is 1 cycle after gntX and rd_dat_o = RAM contents at 5/9.
//  - Write-then-read: req0 writes 0xDEADBEEF at adr 1023, then reads adr 1023 ->
//    rd_vld0=1 two cycles after the write grant, rd_dat_o=0xDEADBEEF.
//  - Lock burst: lck0=1, 8 writes from req0, req1 pending -> gnt1=0 for all 8.
//    After lck0 drops: 1 more cycle of gnt0/no grant, then gnt1=1.
//  - Forced break: MAX_LOCK=4, lck0 held, req0 and req1 pending -> gnt0 for 4 cycles,
//    then gnt1=1 on the next.
//  - Mid-read reset: gnt1 read at cycle N, rstn pulsed low at N+1 -> rd_vld1 stays 0,
//    state ARB, lst_r = 1.

Source files
------------

// File: rtl/ram_sp_1024x32_arb.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port SRAM.
// One access per cycle. An optional lock lets a requester hold the port for a
// burst. The lock is bounded by MAX_LOCK cycles of the other side waiting.
module ram_sp_1024x32_arb #(
  parameter int ADR_WD   = 10,
  parameter int DAT_WD   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_i,
  input  logic              wen0_i,
  input  logic              lck0_i,
  input  logic [ADR_WD-1:0] adr0_i,
  input  logic [DAT_WD-1:0] dat0_i,
  output logic              gnt0_o,
  output logic              rd_vld0_o,
  input  logic              req1_i,
  input  logic              wen1_i,
  input  logic              lck1_i,
  input  logic [ADR_WD-1:0] adr1_i,
  input  logic [DAT_WD-1:0] dat1_i,
  output logic              gnt1_o,
  output logic              rd_vld1_o,
  output logic [DAT_WD-1:0] rd_dat_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);

  // The wait counter only has to reach MAX_LOCK-1. When MAX_LOCK is 0 it is unused
  // and just saturates.
  localparam int CNT_WD = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'((MAX_LOCK > 0) ? MAX_LOCK - 1 : 0);

  typedef enum logic [1:0] {ARB = 2'd0, LCK0 = 2'd1, LCK1 = 2'd2} st_e;

  st_e               st_q;
  logic              lst_q;     // last ARB winner; the other side wins a tie
  logic [CNT_WD-1:0] cnt_q;     // cycles the non-owner has waited during a lock
  logic [1:0]        rd_vld_q;
  logic              gnt0, gnt1;
  logic              brk0, brk1;

  // Forced lock break: the waiting side has been held off for MAX_LOCK locked cycles.
  assign brk0 = (MAX_LOCK != 0) && (cnt_q == CNT_LAST) && req1_i;
  assign brk1 = (MAX_LOCK != 0) && (cnt_q == CNT_LAST) && req0_i;

  // Grant decode. Grants are suppressed while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn) begin
      unique case (st_q)
        ARB: begin
          if (req0_i && req1_i) begin
            gnt0 = lst_q;
            gnt1 = ~lst_q;
          end else begin
            gnt0 = req0_i;
            gnt1 = req1_i;
          end
        end
        LCK0:    gnt0 = req0_i;
        LCK1:    gnt1 = req1_i;
        default: ;
      endcase
    end
  end

  // Lock FSM, round-robin pointer, wait counter and the one-cycle read-valid stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q     <= ARB;
      lst_q    <= 1'b1;
      cnt_q    <= '0;
      rd_vld_q <= '0;
    end else begin
      rd_vld_q <= {gnt1 & ~wen1_i, gnt0 & ~wen0_i};
      unique case (st_q)
        ARB: begin
          if (gnt0 || gnt1) begin
            lst_q <= gnt1;
            cnt_q <= '0;
            if (gnt0 && lck0_i)      st_q <= LCK0;
            else if (gnt1 && lck1_i) st_q <= LCK1;
          end
        end
        LCK0: begin
          if (req1_i && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
          // The release cycle still belongs to the owner. The handover happens at this edge.
          if (!lck0_i || brk0) begin
            st_q  <= ARB;
            lst_q <= 1'b0;
          end
        end
        LCK1: begin
          if (req0_i && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
          if (!lck1_i || brk1) begin
            st_q  <= ARB;
            lst_q <= 1'b1;
          end
        end
        default: st_q <= ARB;
      endcase
    end
  end

  assign gnt0_o       = gnt0;
  assign gnt1_o       = gnt1;
  assign rd_vld0_o    = rd_vld_q[0];
  assign rd_vld1_o    = rd_vld_q[1];
  assign rd_dat_o     = ram_rd_dat_i;
  // With no grant, the address and data buses park on requester 0.
  assign ram_adr_o    = gnt1 ? adr1_i : adr0_i;
  assign ram_wr_dat_o = gnt1 ? dat1_i : dat0_i;
  assign ram_wr_ena_o = (gnt0 & wen0_i) | (gnt1 & wen1_i);
  assign ram_rd_ena_o = (gnt0 & ~wen0_i) | (gnt1 & ~wen1_i);

endmodule

// File: tb/tb_ram_sp_1024x32_arb.sv
// Bench for ram_sp_1024x32_arb. Two instances share the same stimulus:
// instance 0 uses MAX_LOCK=16 and instance 1 uses MAX_LOCK=4.
// Each instance drives its own behavioural 1-cycle-latency RAM.
module tb_ram_sp_1024x32_arb;

  logic        clk;
  logic        rstn;
  logic        req [2];
  logic        wen [2];
  logic        lck [2];
  logic [9:0]  adr [2];
  logic [31:0] dat [2];

  logic        g0 [2], g1 [2], v0 [2], v1 [2], we [2], re [2];
  logic [9:0]  radr [2];
  logic [31:0] wd [2], rdd [2], rdq [2];

  int n_cmp = 0;
  int n_err = 0;

  ram_sp_1024x32_arb #(.ADR_WD(10), .DAT_WD(32), .MAX_LOCK(16)) u_a (
    .clk(clk), .rstn(rstn),
    .req0_i(req[0]), .wen0_i(wen[0]), .lck0_i(lck[0]), .adr0_i(adr[0]), .dat0_i(dat[0]),
    .gnt0_o(g0[0]), .rd_vld0_o(v0[0]),
    .req1_i(req[1]), .wen1_i(wen[1]), .lck1_i(lck[1]), .adr1_i(adr[1]), .dat1_i(dat[1]),
    .gnt1_o(g1[0]), .rd_vld1_o(v1[0]),
    .rd_dat_o(rdd[0]), .ram_adr_o(radr[0]), .ram_wr_ena_o(we[0]),
    .ram_wr_dat_o(wd[0]), .ram_rd_ena_o(re[0]), .ram_rd_dat_i(rdq[0])
  );

  ram_sp_1024x32_arb #(.ADR_WD(10), .DAT_WD(32), .MAX_LOCK(4)) u_b (
    .clk(clk), .rstn(rstn),
    .req0_i(req[0]), .wen0_i(wen[0]), .lck0_i(lck[0]), .adr0_i(adr[0]), .dat0_i(dat[0]),
    .gnt0_o(g0[1]), .rd_vld0_o(v0[1]),
    .req1_i(req[1]), .wen1_i(wen[1]), .lck1_i(lck[1]), .adr1_i(adr[1]), .dat1_i(dat[1]),
    .gnt1_o(g1[1]), .rd_vld1_o(v1[1]),
    .rd_dat_o(rdd[1]), .ram_adr_o(radr[1]), .ram_wr_ena_o(we[1]),
    .ram_wr_dat_o(wd[1]), .ram_rd_ena_o(re[1]), .ram_rd_dat_i(rdq[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Behavioural RAMs. They are preloaded with pat() on the first edge, which falls in reset.
  logic [31:0] ram [2][1024];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 1024; a++) ram[i][a] <= pat(a);
      loaded <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (we[i]) ram[i][radr[i]] <= wd[i];
        if (re[i]) rdq[i] <= ram[i][radr[i]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model, kept separately for each instance.
  // own:  -1 = free arbitration, otherwise the index of the lock owner.
  // last: the most recent winner.
  int          own [2], cnt [2], last [2];
  int          mlim [2];
  bit          vexp [2][2];
  logic [31:0] dexp [2];
  logic [31:0] mm [2][1024];

  task automatic model_step(input int i);
    int w, o;
    bit hit, isw;
    if (!rstn) begin
      chk($sformatf("rst_gnt0_%0d", i), 32'(g0[i]), 0);
      chk($sformatf("rst_gnt1_%0d", i), 32'(g1[i]), 0);
      chk($sformatf("rst_wena_%0d", i), 32'(we[i]), 0);
      chk($sformatf("rst_rena_%0d", i), 32'(re[i]), 0);
      chk($sformatf("rst_vld0_%0d", i), 32'(v0[i]), 0);
      chk($sformatf("rst_vld1_%0d", i), 32'(v1[i]), 0);
      own[i] = -1; cnt[i] = 0; last[i] = 1;
      vexp[i][0] = 0; vexp[i][1] = 0;
      return;
    end
    w = -1;
    if (own[i] >= 0) begin
      if (req[own[i]]) w = own[i];
    end else if (req[0] && req[1]) w = 1 - last[i];
    else if (req[0]) w = 0;
    else if (req[1]) w = 1;
    isw = (w >= 0) ? wen[w] : 1'b0;
    chk($sformatf("gnt0_%0d", i), 32'(g0[i]), 32'(w == 0));
    chk($sformatf("gnt1_%0d", i), 32'(g1[i]), 32'(w == 1));
    chk($sformatf("wena_%0d", i), 32'(we[i]), 32'(w >= 0 && isw));
    chk($sformatf("rena_%0d", i), 32'(re[i]), 32'(w >= 0 && !isw));
    chk($sformatf("radr_%0d", i), 32'(radr[i]), 32'((w >= 0) ? adr[w] : adr[0]));
    if (w >= 0 && isw) chk($sformatf("wdat_%0d", i), wd[i], dat[w]);
    chk($sformatf("vld0_%0d", i), 32'(v0[i]), 32'(vexp[i][0]));
    chk($sformatf("vld1_%0d", i), 32'(v1[i]), 32'(vexp[i][1]));
    if (vexp[i][0] || vexp[i][1]) chk($sformatf("rdat_%0d", i), rdd[i], dexp[i]);
    // Advance the model to the state it will hold after the next rising edge.
    vexp[i][0] = 0; vexp[i][1] = 0;
    if (w >= 0) begin
      if (isw) mm[i][adr[w]] = dat[w];
      else begin
        vexp[i][w] = 1;
        dexp[i] = mm[i][adr[w]];
      end
    end
    if (own[i] < 0) begin
      if (w >= 0) begin
        last[i] = w;
        if (lck[w]) begin own[i] = w; cnt[i] = 0; end
      end
    end else begin
      o   = 1 - own[i];
      hit = (mlim[i] != 0) && (cnt[i] == mlim[i] - 1) && req[o];
      if (req[o]) cnt[i]++;
      if (!lck[own[i]] || hit) begin
        last[i] = own[i];
        own[i]  = -1;
      end
    end
  endtask

  initial begin
    mlim[0] = 16; mlim[1] = 4;
    for (int i = 0; i < 2; i++) begin
      own[i] = -1; cnt[i] = 0; last[i] = 1; vexp[i][0] = 0; vexp[i][1] = 0; dexp[i] = '0;
      for (int a = 0; a < 1024; a++) mm[i][a] = pat(a);
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus. The literal checks below are computed by hand and pin the model.
  initial begin
    rstn = 1'b1;
    req[0] = 1; req[1] = 1; wen[0] = 0; wen[1] = 0; lck[0] = 0; lck[1] = 0;
    adr[0] = 10'd5; adr[1] = 10'd9; dat[0] = '0; dat[1] = '0;
    #1 rstn = 1'b0;
    #1;
    chk("lit_rst_gnt0", 32'(g0[0]), 0);
    chk("lit_rst_rena", 32'(re[0]), 0);
    chk("lit_rst_vld0", 32'(v0[0]), 0);
    tick; tick;
    rstn = 1'b1;
    #1;
    chk("lit_first_gnt0", 32'(g0[0]), 1);
    chk("lit_first_gnt1", 32'(g1[0]), 0);
    tick; #1;
    chk("lit_tie_gnt1", 32'(g1[0]), 1);
    chk("lit_tie_vld0", 32'(v0[0]), 1);
    chk("lit_tie_rdat5", rdd[0], 32'hC0DE0005);
    tick; #1;
    chk("lit_tie_gnt0", 32'(g0[0]), 1);
    chk("lit_tie_vld1", 32'(v1[0]), 1);
    chk("lit_tie_rdat9", rdd[0], 32'hC0DE0009);
    tick; tick;

    // Write, then read back, at the top address.
    req[1] = 0; wen[0] = 1; adr[0] = 10'd1023; dat[0] = 32'hDEADBEEF;
    #1;
    chk("lit_wr_gnt0", 32'(g0[0]), 1);
    chk("lit_wr_wena", 32'(we[0]), 1);
    tick;
    wen[0] = 0;
    #1 chk("lit_rd_rena", 32'(re[0]), 1);
    tick;
    req[0] = 0;
    #1;
    chk("lit_rd_vld0", 32'(v0[0]), 1);
    chk("lit_rd_dat", rdd[0], 32'hDEADBEEF);
    tick;

    // Lock burst. Instance 0 holds the lock for all 8 writes. Instance 1 is forced
    // off after 4 locked cycles, and requester 1 wins at k=5.
    for (int k = 0; k < 8; k++) begin
      req[0] = 1; wen[0] = 1; lck[0] = 1; adr[0] = 10'(100 + k); dat[0] = 32'h1000 + 32'(k);
      req[1] = (k >= 1); wen[1] = 0; adr[1] = 10'd9;
      #1;
      chk($sformatf("lit_lck_gnt0_k%0d", k), 32'(g0[0]), 1);
      chk($sformatf("lit_lck_gnt1_k%0d", k), 32'(g1[0]), 0);
      if (k >= 1 && k <= 4) chk($sformatf("lit_brk_gnt0_k%0d", k), 32'(g0[1]), 1);
      if (k == 5) chk("lit_brk_gnt1", 32'(g1[1]), 1);
      tick;
    end
    req[0] = 0; lck[0] = 0;
    #1;
    chk("lit_rel_gnt0", 32'(g0[0]), 0);
    chk("lit_rel_gnt1", 32'(g1[0]), 0);
    tick;
    #1 chk("lit_after_rel_gnt1", 32'(g1[0]), 1);
    tick;

    // Reset in the cycle after a read grant. The pending valid must be dropped.
    rstn = 1'b0; req[0] = 1;
    #1;
    chk("lit_midrst_vld1", 32'(v1[0]), 0);
    chk("lit_midrst_gnt0", 32'(g0[0]), 0);
    tick;
    rstn = 1'b1;
    #1;
    chk("lit_postrst_gnt0", 32'(g0[0]), 1);
    chk("lit_postrst_gnt1", 32'(g1[0]), 0);
    tick;

    // Mixed traffic, checked by the model only.
    for (int n = 0; n < 120; n++) begin
      for (int r = 0; r < 2; r++) begin
        req[r] = 1'($urandom_range(0, 1));
        wen[r] = 1'($urandom_range(0, 1));
        lck[r] = ($urandom_range(0, 3) == 0);
        adr[r] = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
        dat[r] = $urandom;
      end
      tick;
    end
    req[0] = 0; req[1] = 0; lck[0] = 0; lck[1] = 0;
    tick; tick; tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
